// File: rtl/dom_pkg.sv
// Shared helpers for the domain-oriented masking (DOM-indep) AND gadget:
// share-count derivation, fresh-randomness word count and the mapping from
// a share pair (i,j) to its packed randomness word.
package dom_pkg;

    // Default geometry of the 2-share gadget used across the masked datapath.
    localparam int DOM_DEF_WIDTH = 4;
    localparam int DOM_DEF_ORDER = 1;

    // Role of one entry of the SHARES x SHARES term matrix.
    typedef enum logic [1:0] {
        TERM_INNER = 2'd0,  // i == j : x_i & y_i, stays inside its domain
        TERM_UPPER = 2'd1,  // i <  j : masked with r_ij
        TERM_LOWER = 2'd2   // i >  j : masked with r_ji
    } term_kind_e;

    // Number of shares for a given masking order.
    function automatic int shares_of(input int order);
        return order + 1;
    endfunction

    // Fresh WIDTH-bit random words needed per operation: one per unordered pair.
    function automatic int nrnd(input int shares);
        return shares * (shares - 1) / 2;
    endfunction

    // Lexicographic index of pair (i,j), i<j: (0,1),(0,2),...,(1,2),...
    // Rows before i contribute (shares-1-k) pairs each.
    function automatic int rnd_idx(input int i, input int j, input int shares);
        return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Classify a term matrix entry.
    function automatic term_kind_e term_kind(input int i, input int j);
        if (i == j) begin
            return TERM_INNER;
        end else if (i < j) begin
            return TERM_UPPER;
        end
        return TERM_LOWER;
    endfunction

    // Randomness word masking term (i,j); both (i,j) and (j,i) share one word.
    function automatic int term_rnd_idx(input int i, input int j, input int shares);
        if (i < j) begin
            return rnd_idx(i, j, shares);
        end
        return rnd_idx(j, i, shares);
    endfunction

endpackage

// File: rtl/dom_cross_term.sv
// One registered entry of the DOM term matrix: t = (x_i & y_j) ^ r.
// Inner-domain terms are built with r tied to zero. The register is the
// glitch barrier: nothing downstream ever sees x/y/r combinationally.
module dom_cross_term #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] r_i,
    output logic [WIDTH-1:0] t_o
);

    logic [WIDTH-1:0] t_d;
    logic [WIDTH-1:0] t_q;

    assign t_d = (x_i & y_i) ^ r_i;

    // Capture the masked partial product only on acceptance; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
        end else if (en_i) begin
            t_q <= t_d;
        end
    end

    assign t_o = t_q;

endmodule

// File: rtl/dom_and_pipe.sv
// d-th order DOM-indep masked AND, two-stage valid/ready pipeline.
// Stage 1 registers all SHARES*SHARES partial products (cross-domain ones
// remasked with fresh randomness); stage 2 compresses each row by XOR into
// the output share. Randomness is consumed only together with operands.
module dom_and_pipe
    import dom_pkg::*;
#(
    parameter  int WIDTH  = DOM_DEF_WIDTH,
    parameter  int ORDER  = DOM_DEF_ORDER,
    localparam int SHARES = shares_of(ORDER),
    parameter  int NRND   = nrnd(SHARES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SHARES*WIDTH-1:0] x_sh,
    input  logic [SHARES*WIDTH-1:0] y_sh,
    input  logic                    rnd_valid,
    output logic                    rnd_ready,
    input  logic [NRND*WIDTH-1:0]   rnd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SHARES*WIDTH-1:0] z_sh
);

    logic                    s1_valid_q;
    logic                    out_valid_q;
    logic [SHARES*WIDTH-1:0] z_d;
    logic [SHARES*WIDTH-1:0] z_q;
    logic [WIDTH-1:0]        term_q [SHARES][SHARES];

    logic s2_en;
    logic s1_en;
    logic acc;

    // Handshake: stage 2 advances when empty or drained; stage 1 when empty or
    // it can move into stage 2. Reset forces both readies low.
    assign s2_en     = !out_valid_q || out_ready;
    assign s1_en     = rst_n && (!s1_valid_q || s2_en);
    assign acc       = in_valid && rnd_valid && s1_en;
    assign in_ready  = s1_en;
    assign rnd_ready = acc;

    // ---- stage 1: registered term matrix ----
    for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
        for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
            localparam term_kind_e KIND = term_kind(gi, gj);
            logic [WIDTH-1:0] r_sel;

            if (KIND == TERM_INNER) begin : g_inner
                assign r_sel = '0;
            end else begin : g_cross
                localparam int RI = term_rnd_idx(gi, gj, SHARES);
                assign r_sel = rnd[RI*WIDTH +: WIDTH];
            end

            dom_cross_term #(
                .WIDTH (WIDTH)
            ) u_term (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (acc),
                .x_i   (x_sh[gi*WIDTH +: WIDTH]),
                .y_i   (y_sh[gj*WIDTH +: WIDTH]),
                .r_i   (r_sel),
                .t_o   (term_q[gi][gj])
            );
        end
    end

    // Stage-1 occupancy: filled on accept, emptied when it moves on unreplaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= acc;
        end
    end

    // ---- stage 2: per-domain compression of registered terms ----
    // Row i of the term matrix folds into output share i.
    always_comb begin
        z_d = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                z_d[i*WIDTH +: WIDTH] = z_d[i*WIDTH +: WIDTH] ^ term_q[i][j];
            end
        end
    end

    // Output shares and valid; frozen while downstream back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            z_q         <= z_d;
        end
    end

    assign out_valid = out_valid_q;
    assign z_sh      = z_q;

endmodule

// File: tb/tb_dom_and_pipe.sv
// Scoreboard bench for dom_and_pipe: a directed 2-share/4-bit instance and a
// randomized 3-share/8-bit instance, both checked against a share-level model.
module tb_dom_and_pipe;

    localparam int AW = 4;
    localparam int AO = 1;
    localparam int AS = 2;
    localparam int AN = 1;
    localparam int BW = 8;
    localparam int BO = 2;
    localparam int BS = 3;
    localparam int BN = 3;
    localparam int BOPS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT A ----------------
    logic              a_rst_n, a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready;
    logic              a_out_valid, a_out_ready;
    logic [AS*AW-1:0]  a_x_sh, a_y_sh, a_z_sh;
    logic [AN*AW-1:0]  a_rnd;

    dom_and_pipe #(.WIDTH(AW), .ORDER(AO)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x_sh(a_x_sh), .y_sh(a_y_sh), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
        .rnd(a_rnd), .out_valid(a_out_valid), .out_ready(a_out_ready), .z_sh(a_z_sh)
    );

    // ---------------- DUT B ----------------
    logic              b_rst_n, b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready;
    logic              b_out_valid, b_out_ready;
    logic [BS*BW-1:0]  b_x_sh, b_y_sh, b_z_sh;
    logic [BN*BW-1:0]  b_rnd;

    dom_and_pipe #(.WIDTH(BW), .ORDER(BO)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x_sh(b_x_sh), .y_sh(b_y_sh), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
        .rnd(b_rnd), .out_valid(b_out_valid), .out_ready(b_out_ready), .z_sh(b_z_sh)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] xor_fold(input logic [63:0] v, input int s, input int w);
        logic [63:0] m;
        logic [63:0] acc;
        m = (64'd1 << w) - 64'd1;
        acc = 64'd0;
        for (int i = 0; i < s; i++) acc = acc ^ ((v >> (i * w)) & m);
        return acc;
    endfunction

    // Output shares from the gadget's definition: share i collects x_i & y_j
    // over all j, with every unordered pair {i,j} masked by its own word.
    function automatic logic [63:0] model_z(input int s, input int w, input logic [63:0] x,
                                            input logic [63:0] y, input logic [63:0] r);
        logic [63:0] m;
        logic [63:0] rw [8][8];
        logic [63:0] z;
        logic [63:0] zi;
        int k;
        m = (64'd1 << w) - 64'd1;
        k = 0;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) rw[i][j] = 64'd0;
        for (int i = 0; i < s; i++) begin
            for (int j = i + 1; j < s; j++) begin
                rw[i][j] = (r >> (k * w)) & m;
                rw[j][i] = rw[i][j];
                k++;
            end
        end
        z = 64'd0;
        for (int i = 0; i < s; i++) begin
            zi = 64'd0;
            for (int j = 0; j < s; j++)
                zi = zi ^ (((x >> (i * w)) & (y >> (j * w)) & m) ^ rw[i][j]);
            z = z | (zi << (i * w));
        end
        return z;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic [63:0] qa_z[$], qa_p[$], qb_z[$], qb_p[$];
    logic [63:0] ea_z, ea_p, eb_z, eb_p;
    int b_pushes = 0;
    int b_rnd_pulses = 0;

    // Input monitors: record expected result whenever an operation is accepted.
    always @(negedge clk) begin
        if (a_rst_n && a_in_valid && a_rnd_valid && a_in_ready) begin
            qa_z.push_back(model_z(AS, AW, 64'(a_x_sh), 64'(a_y_sh), 64'(a_rnd)));
            qa_p.push_back(xor_fold(64'(a_x_sh), AS, AW) & xor_fold(64'(a_y_sh), AS, AW));
        end
        if (b_rst_n && b_in_valid && b_rnd_valid && b_in_ready) begin
            qb_z.push_back(model_z(BS, BW, 64'(b_x_sh), 64'(b_y_sh), 64'(b_rnd)));
            qb_p.push_back(xor_fold(64'(b_x_sh), BS, BW) & xor_fold(64'(b_y_sh), BS, BW));
            b_pushes++;
        end
        if (b_rst_n && b_rnd_ready) b_rnd_pulses++;
    end

    // Output monitors: compare every delivered result in order.
    always @(negedge clk) begin
        if (a_rst_n && a_out_valid && a_out_ready) begin
            if (qa_z.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_out: got z=%0h, required no output", a_z_sh);
            end else begin
                ea_z = qa_z.pop_front();
                ea_p = qa_p.pop_front();
                chk("a_z_shares", 64'(a_z_sh), ea_z);
                chk("a_z_xor", xor_fold(64'(a_z_sh), AS, AW), ea_p);
            end
        end
        if (b_rst_n && b_out_valid && b_out_ready) begin
            if (qb_z.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_out: got z=%0h, required no output", b_z_sh);
            end else begin
                eb_z = qb_z.pop_front();
                eb_p = qb_p.pop_front();
                chk("b_z_shares", 64'(b_z_sh), eb_z);
                chk("b_z_xor", xor_fold(64'(b_z_sh), BS, BW), eb_p);
            end
        end
    end

    // ---------------- DUT A drivers ----------------
    task automatic a_send(input logic [7:0] x, input logic [7:0] y, input logic [3:0] r);
        int n;
        a_x_sh = x; a_y_sh = y; a_rnd = r;
        a_in_valid = 1'b1; a_rnd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) begin
            tests++; fails++;
            $display("FAIL a_send_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_rnd_valid = 1'b0;
    endtask

    task automatic a_drain();
        int n;
        n = 0;
        while ((qa_z.size() != 0 || a_out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("a_drain_pending", 64'(qa_z.size()), 64'd0);
    endtask

    logic [7:0] bp_x [4] = '{8'h93, 8'h5A, 8'hF1, 8'h2E};
    logic [7:0] bp_y [4] = '{8'h35, 8'hC3, 8'h7F, 8'hB4};
    logic [3:0] bp_r [4] = '{4'hC, 4'h6, 4'h1, 4'h9};

    logic       b_run = 1'b0;

    initial begin
        logic [3:0] z0_r0, z0_rf;
        logic       acc;
        int         cnt;

        a_rst_n = 1'b0; a_in_valid = 1'b1; a_rnd_valid = 1'b1; a_out_ready = 1'b1;
        a_x_sh = '0; a_y_sh = '0; a_rnd = '0;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_rnd_valid = 1'b0; b_out_ready = 1'b1;
        b_x_sh = '0; b_y_sh = '0; b_rnd = '0;

        // Reset state
        #3;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_z_sh", 64'(a_z_sh), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_rnd_ready", 64'(a_rnd_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        a_in_valid = 1'b0; a_rnd_valid = 1'b0;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;

        // Known vector X=A, Y=6, r=C; two-cycle latency
        a_send(8'h93, 8'h35, 4'hC);
        chk("lat_not_yet", 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_out_valid", 64'(a_out_valid), 64'd1);
        chk("known_z_sh", 64'(a_z_sh), 64'hCE);

        // Same operands, different randomness
        a_send(8'h93, 8'h35, 4'h0);
        @(posedge clk); #1;
        z0_r0 = a_z_sh[3:0];
        chk("r0_xor", xor_fold(64'(a_z_sh), AS, AW), 64'h2);
        a_send(8'h93, 8'h35, 4'hF);
        @(posedge clk); #1;
        z0_rf = a_z_sh[3:0];
        chk("rf_xor", xor_fold(64'(a_z_sh), AS, AW), 64'h2);
        chk("z0_differs", 64'(z0_r0 != z0_rf), 64'd1);
        a_drain();

        // Backpressure
        a_out_ready = 1'b0;
        a_send(bp_x[0], bp_y[0], bp_r[0]);
        a_send(bp_x[1], bp_y[1], bp_r[1]);
        chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
            chk("bp_hold_z", 64'(a_z_sh), model_z(AS, AW, 64'(bp_x[0]), 64'(bp_y[0]), 64'(bp_r[0])));
            chk("bp_hold_in_ready", 64'(a_in_ready), 64'd0);
        end
        a_out_ready = 1'b1;
        a_send(bp_x[2], bp_y[2], bp_r[2]);
        a_send(bp_x[3], bp_y[3], bp_r[3]);
        a_drain();

        // Randomness starvation
        a_x_sh = 8'h6D; a_y_sh = 8'hA7; a_rnd = 4'h5;
        a_in_valid = 1'b1; a_rnd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("starve_rnd_ready", 64'(a_rnd_ready), 64'd0);
            chk("starve_out_valid", 64'(a_out_valid), 64'd0);
            chk("starve_z_held", 64'(a_z_sh), model_z(AS, AW, 64'(bp_x[3]), 64'(bp_y[3]), 64'(bp_r[3])));
        end
        @(posedge clk); #1;
        a_send(8'h6D, 8'hA7, 4'h5);
        a_drain();

        // Reset mid-flight
        a_send(8'hB2, 8'hE9, 4'h3);
        a_rst_n = 1'b0;
        a_in_valid = 1'b1; a_rnd_valid = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_z_sh", 64'(a_z_sh), 64'd0);
        chk("midrst_rnd_ready", 64'(a_rnd_ready), 64'd0);
        qa_z.delete(); qa_p.delete();
        repeat (2) @(posedge clk);
        #1;
        a_in_valid = 1'b0; a_rnd_valid = 1'b0;
        a_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("postrst_no_stale", 64'(a_out_valid), 64'd0);
        end
        @(posedge clk); #1;
        a_send(8'h47, 8'h1C, 4'hA);
        a_drain();

        // Randomized 3-share / 8-bit run
        b_run = 1'b1;
        fork
            while (b_run) begin
                @(posedge clk); #1;
                if (b_run) b_out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int n = 0; n < BOPS; n++) begin
            b_x_sh = 24'($urandom); b_y_sh = 24'($urandom); b_rnd = 24'($urandom);
            b_in_valid = 1'b1;
            cnt = 0;
            do begin
                b_rnd_valid = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = b_in_valid && b_rnd_valid && b_in_ready;
                @(posedge clk); #1;
                cnt++;
            end while (!acc && cnt < 200);
            if (!acc) begin
                tests++; fails++;
                $display("FAIL b_accept_timeout: got no accept in %0d cycles, required accept", cnt);
                break;
            end
            if ($urandom_range(0, 4) == 0) begin
                b_in_valid = 1'b0;
                b_rnd_valid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        b_in_valid = 1'b0; b_rnd_valid = 1'b0;
        b_run = 1'b0;
        @(posedge clk); #2;
        b_out_ready = 1'b1;
        cnt = 0;
        while ((qb_z.size() != 0 || b_out_valid) && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("b_drain_pending", 64'(qb_z.size()), 64'd0);
        chk("b_ops_accepted", 64'(b_pushes), 64'(BOPS));
        chk("b_rnd_words", 64'(b_rnd_pulses * BN), 64'(BOPS * 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by 400000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
